joypad_scanner: RTL
===================

// Module: joypad_scanner
// PURPOSE
// Autonomous multi-pad serial scanner plus CPU-side $4016/$4017 shift-register emulation for the NES core.
// Periodically latches and clocks up to 4 serial pads (8-bit NES or 16-bit SNES), stores an atomic snapshot,
// and serves CPU reads bit-serially with standard strobe semantics. Sits beside the APU register decode on the CPU bus.
// PARAMETERS
// NUM_PADS     2      pads scanned, 1..4; pads 0,2 -> $4016 bit0,bit1; pads 1,3 -> $4017 bit0,bit1
// PAD_BITS     8      bits shifted per pad per scan (8 NES, 16 SNES)
// CLK_DIV      6      clk cycles per pad_latch/pad_clk half-phase; >=4
// SCAN_PERIOD  29780  clk cycles between automatic scan starts; 0 = scans only on scan_req
// PORTS
// clk          in   1                   system clock
// rst          in   1                   asynchronous active-high reset
// addr         in   16                  CPU address
// wren         in   1                   CPU write strobe; qualifies from_cpu
// rden         in   1                   one-cycle pulse per CPU read access
// from_cpu     in   8                   CPU write data; bit0 = strobe
// to_cpu       out  8                   read data: {1'b0, cs, 4'h0, b1, b0}; 0 when no cs
// pad_data     in   NUM_PADS            raw serial data, active-low (pressed = 0)
// pad_clk      out  1                   shared pad shift clock
// pad_latch    out  1                   shared pad parallel-load strobe
// scan_req     in   1                   one-cycle request for an immediate scan
// snap_valid   out  1                   one-cycle pulse on snapshot commit
// pad_state    out  NUM_PADS*PAD_BITS   committed snapshot, active-high, pad n at [n*PAD_BITS +: PAD_BITS], bit0 = first shifted (A)
// BEHAVIOUR
// - Reset (async): pad_clk=0, pad_latch=0, snap_valid=0, pad_state=0, shadow regs=0, strobe=0, FSM IDLE, period counter=0.
// - pad_data passes through 2-FF synchroniser before any use.
// - Scan FSM: IDLE -> LATCH -> SETTLE -> CLK_HI -> CLK_LO -> ... -> COMMIT -> IDLE.
//   IDLE: start when scan_req, or period counter reaches SCAN_PERIOD-1 (counter then wraps to 0).
//   LATCH: pad_latch=1 for CLK_DIV cycles. SETTLE: latch=0 for CLK_DIV cycles; sample bit0 on last cycle.
//   CLK_HI: pad_clk=1 CLK_DIV cycles; CLK_LO: pad_clk=0 CLK_DIV cycles, sample next bit on last cycle.
//   After PAD_BITS samples taken (PAD_BITS-1 clock pulses), COMMIT: pad_state <= inverted samples, snap_valid=1 one cycle.
// - Scan length = (2 + 2*(PAD_BITS-1))*CLK_DIV + 1 cycles; scan_req or period expiry while busy ignored (period counter keeps running).
// - Samples collected in a working register; pad_state changes only at COMMIT (never partially updated).
// - CPU strobe: write to $4016 (wren) sets strobe <= from_cpu[0]; $4017 write ignored here (APU frame counter).
// - While strobe=1: every cycle shadow[n] <= pad_state[n]; reads return pad_state bit0, no shift.
// - strobe 1->0: shadow holds last loaded value (loaded on the final strobe=1 cycle).
// - While strobe=0: rden at $4016 returns shadow[0][0] (bit0), shadow[2][0] (bit1) then shifts those right, filling 1.
//   $4017 likewise for pads 1,3. After PAD_BITS reads a port returns 1; absent pads (n>=NUM_PADS) read 0.
// - to_cpu is combinational from addr and current shadow; shift occurs on clk edge when rden=1.
// - COMMIT coincident with strobe=1: shadow gets old snapshot that edge, new snapshot next edge.
// - COMMIT coincident with rden, strobe=0: shift proceeds on old shadow; new snapshot not visible until re-strobe.
// - wren and rden same cycle on $4016: write takes effect, no shift.
// - rst mid-scan aborts immediately; pad_clk/pad_latch drop asynchronously; no commit.
// STRUCTURE
// - Package joypad_pkg: scan_state_t enum (IDLE, LATCH, SETTLE, CLK_HI, CLK_LO, COMMIT),
//   constants JP1_ADDR=16'h4016, JP2_ADDR=16'h4017, OPEN_BUS_BIT=6.
// - Sub-module joypad_shadow (PAD_BITS param): parallel-load/shift-right, fill-1 register; NUM_PADS instances.
// - Top holds synchroniser, phase counter, bit counter, period counter, FSM, strobe flop, read mux.
// TESTING
// - Reset, NUM_PADS=2, PAD_BITS=8, CLK_DIV=6, scan_req: latch high 6 cyc, 7 clk pulses, commit at cycle 97; snap_valid 1 cycle.
// - Pad0 serial 0,1,1,1,1,1,1,0 (active-low) -> pad_state[7:0]=8'h81; pad1 all 1s -> pad_state[15:8]=8'h00.
// - Write $4016=1 then 0, 10 reads $4016 -> to_cpu 8'h41,00,00,00,00,00,00,41,41,41.
// - Strobe held 1, 3 reads $4016 -> 8'h41 each, no shift; $4017 read -> 8'h40 (pad1 bit0 = 0).
// - PAD_BITS=16, NUM_PADS=4: pad2 A pressed -> $4016 first read 8'h42; 17th read 8'h43.
// - Assert rst during CLK_HI -> pad_clk=0 same cycle, pad_state stays 0, next scan completes normally.
// - SCAN_PERIOD=200: snap_valid pulses every 200 cycles; scan_req mid-scan causes no extra pulse.

Source files
------------

// File: rtl/joypad_pkg.sv
// Shared types and constants for the joypad scanner: scan FSM states, CPU port addresses,
// and the read-byte formatter used by the $4016/$4017 read mux.
package joypad_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      SETTLE,
      CLK_HI,
      CLK_LO,
      COMMIT
   } scan_state_t;

   localparam logic [15:0] JP1_ADDR     = 16'h4016;
   localparam logic [15:0] JP2_ADDR     = 16'h4017;
   localparam int unsigned OPEN_BUS_BIT = 6;

   // Bit 6 marks a decoded joypad port; data lines sit in bits 1:0.
   function automatic logic [7:0] cpu_read_byte(input logic b1, input logic b0);
      logic [7:0] r;
      r               = '0;
      r[OPEN_BUS_BIT] = 1'b1;
      r[1]            = b1;
      r[0]            = b0;
      return r;
   endfunction

endpackage

// File: rtl/joypad_shadow.sv
// CPU-visible shift register for one pad: parallel load from the snapshot, shift right
// on each read, filling with 1 so exhausted ports read as 1.
module joypad_shadow
   import joypad_pkg::*;
#(
   parameter int unsigned PAD_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_i,
   input  logic                shift_i,
   input  logic [PAD_BITS-1:0] data_i,
   output logic                bit0_o
);

   logic [PAD_BITS-1:0] shadow_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= '0;
      end else if (load_i) begin
         shadow_q <= data_i;
      end else if (shift_i) begin
         shadow_q <= {1'b1, shadow_q[PAD_BITS-1:1]};
      end
   end

   assign bit0_o = shadow_q[0];

endmodule

// File: rtl/joypad_scanner.sv
// Multi-pad serial scanner with atomic snapshot, plus NES $4016/$4017 strobe and
// bit-serial read emulation on the CPU bus.
module joypad_scanner
   import joypad_pkg::*;
#(
   parameter int unsigned NUM_PADS    = 2,
   parameter int unsigned PAD_BITS    = 8,
   parameter int unsigned CLK_DIV     = 6,
   parameter int unsigned SCAN_PERIOD = 29780
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [15:0]                  addr,
   input  logic                         wren,
   input  logic                         rden,
   input  logic [7:0]                   from_cpu,
   output logic [7:0]                   to_cpu,
   input  logic [NUM_PADS-1:0]          pad_data,
   output logic                         pad_clk,
   output logic                         pad_latch,
   input  logic                         scan_req,
   output logic                         snap_valid,
   output logic [NUM_PADS*PAD_BITS-1:0] pad_state
);

   localparam int unsigned SNAP_W = NUM_PADS * PAD_BITS;
   localparam int unsigned PH_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BIT_W  = (PAD_BITS > 1) ? $clog2(PAD_BITS) : 1;
   localparam int unsigned PER_W  = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

   logic [NUM_PADS-1:0] sync1_q;
   logic [NUM_PADS-1:0] sync2_q;
   scan_state_t         state_q;
   logic [PH_W-1:0]     phase_q;
   logic [BIT_W-1:0]    bit_q;
   logic [PER_W-1:0]    period_q;
   logic [SNAP_W-1:0]   work_q;
   logic [SNAP_W-1:0]   pad_state_q;
   logic                pad_clk_q;
   logic                pad_latch_q;
   logic                snap_valid_q;
   logic                strobe_q;

   logic                phase_end_c;
   logic                last_bit_c;
   logic                period_hit_c;
   logic                start_c;
   logic [PAD_BITS-1:0] bit_mask_c;
   logic [SNAP_W-1:0]   sampled_c;
   logic                jp1_c;
   logic                jp2_c;
   logic                shift_p0_c;
   logic                shift_p1_c;
   logic [3:0]          sh_bit_c;
   logic                unused_from_cpu_c;

   assign phase_end_c  = (phase_q == PH_W'(CLK_DIV - 1));
   assign last_bit_c   = (bit_q == BIT_W'(PAD_BITS - 1));
   assign period_hit_c = (SCAN_PERIOD != 0) && (period_q == PER_W'(SCAN_PERIOD - 1));
   assign start_c      = scan_req || period_hit_c;
   assign bit_mask_c   = PAD_BITS'(1) << bit_q;

   // Working register with the current bit of every pad merged in, stored active-high.
   for (genvar g = 0; g < NUM_PADS; g++) begin : g_sample
      assign sampled_c[g*PAD_BITS +: PAD_BITS] = sync2_q[g]
         ? (work_q[g*PAD_BITS +: PAD_BITS] & ~bit_mask_c)
         : (work_q[g*PAD_BITS +: PAD_BITS] |  bit_mask_c);
   end

   // Synchroniser, period counter and scan FSM; pad outputs are registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         state_q      <= IDLE;
         phase_q      <= '0;
         bit_q        <= '0;
         period_q     <= '0;
         work_q       <= '0;
         pad_state_q  <= '0;
         pad_clk_q    <= 1'b0;
         pad_latch_q  <= 1'b0;
         snap_valid_q <= 1'b0;
      end else begin
         sync1_q      <= pad_data;
         sync2_q      <= sync1_q;
         snap_valid_q <= 1'b0;
         phase_q      <= phase_end_c ? '0 : phase_q + PH_W'(1);
         if (SCAN_PERIOD != 0) begin
            period_q <= period_hit_c ? '0 : period_q + PER_W'(1);
         end

         case (state_q)
            IDLE: begin
               phase_q <= '0;
               bit_q   <= '0;
               if (start_c) begin
                  state_q     <= LATCH;
                  pad_latch_q <= 1'b1;
               end
            end
            LATCH: begin
               if (phase_end_c) begin
                  state_q     <= SETTLE;
                  pad_latch_q <= 1'b0;
               end
            end
            SETTLE: begin
               if (phase_end_c) begin
                  work_q <= sampled_c;
                  if (last_bit_c) begin
                     pad_state_q  <= sampled_c;
                     snap_valid_q <= 1'b1;
                     state_q      <= COMMIT;
                  end else begin
                     bit_q     <= bit_q + BIT_W'(1);
                     pad_clk_q <= 1'b1;
                     state_q   <= CLK_HI;
                  end
               end
            end
            CLK_HI: begin
               if (phase_end_c) begin
                  pad_clk_q <= 1'b0;
                  state_q   <= CLK_LO;
               end
            end
            CLK_LO: begin
               if (phase_end_c) begin
                  work_q <= sampled_c;
                  if (last_bit_c) begin
                     pad_state_q  <= sampled_c;
                     snap_valid_q <= 1'b1;
                     state_q      <= COMMIT;
                  end else begin
                     bit_q     <= bit_q + BIT_W'(1);
                     pad_clk_q <= 1'b1;
                     state_q   <= CLK_HI;
                  end
               end
            end
            COMMIT: begin
               state_q <= IDLE;
            end
            default: begin
               state_q     <= IDLE;
               pad_clk_q   <= 1'b0;
               pad_latch_q <= 1'b0;
            end
         endcase
      end
   end

   assign jp1_c = (addr == JP1_ADDR);
   assign jp2_c = (addr == JP2_ADDR);

   // Only $4016 writes reach the strobe; $4017 belongs to the APU frame counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         strobe_q <= 1'b0;
      end else if (wren && jp1_c) begin
         strobe_q <= from_cpu[0];
      end
   end

   assign shift_p0_c = rden && jp1_c && !wren && !strobe_q;
   assign shift_p1_c = rden && jp2_c && !strobe_q;

   for (genvar g = 0; g < 4; g++) begin : g_pad
      if (g < NUM_PADS) begin : g_on
         joypad_shadow #(
            .PAD_BITS(PAD_BITS)
         ) u_shadow (
            .clk    (clk),
            .rst    (rst),
            .load_i (strobe_q),
            .shift_i((g % 2 == 0) ? shift_p0_c : shift_p1_c),
            .data_i (pad_state_q[g*PAD_BITS +: PAD_BITS]),
            .bit0_o (sh_bit_c[g])
         );
      end else begin : g_off
         assign sh_bit_c[g] = 1'b0;
      end
   end

   always_comb begin
      to_cpu = '0;
      if (jp1_c) begin
         to_cpu = cpu_read_byte(sh_bit_c[2], sh_bit_c[0]);
      end else if (jp2_c) begin
         to_cpu = cpu_read_byte(sh_bit_c[3], sh_bit_c[1]);
      end
   end

   assign unused_from_cpu_c = ^from_cpu[7:1];

   assign pad_clk    = pad_clk_q;
   assign pad_latch  = pad_latch_q;
   assign snap_valid = snap_valid_q;
   assign pad_state  = pad_state_q;

endmodule
